// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_pkg
//  Purpose  : Shared constants and the threshold-select helper for the
//             pwm_clock_divider block.
//  Contents : MODE_HALF / MODE_DUTY channel mode encodings, MAX_WIDTH,
//             wide_t, threshold_sel()
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

   // Channel mode encodings
   localparam logic MODE_HALF = 1'b0;   // threshold = period / 2
   localparam logic MODE_DUTY = 1'b1;   // threshold = explicit duty value

   // Widest counter the helper supports; instances must use WIDTH <= MAX_WIDTH.
   localparam int MAX_WIDTH = 64;

   typedef logic [MAX_WIDTH-1:0] wide_t;

   // High-time threshold for one channel. The half-period case truncates, so an
   // odd period is biased low (P=5 -> 2 high, 3 low).
   function automatic wide_t threshold_sel(input logic mode,
                                           input wide_t duty,
                                           input wide_t period);
      return (mode == MODE_DUTY) ? duty : (period >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_clock_divider_if.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_clock_divider_if
//  Purpose  : Control/status bundle for pwm_clock_divider.
//  Signals  : enable, load, period_in, duty_in, mode_in  (master -> slave)
//             q, tick, pending                           (slave -> master)
//  Modports : master (controller / testbench), slave (divider)
//  Revision : 1.0 - initial release
// ============================================================================
interface pwm_clock_divider_if #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 2
);
   logic                      enable;
   logic                      load;
   logic [WIDTH-1:0]          period_in;
   logic [CHANNELS*WIDTH-1:0] duty_in;
   logic [CHANNELS-1:0]       mode_in;
   logic [CHANNELS-1:0]       q;
   logic                      tick;
   logic                      pending;

   modport master (
      output enable, load, period_in, duty_in, mode_in,
      input  q, tick, pending
   );

   modport slave (
      input  enable, load, period_in, duty_in, mode_in,
      output q, tick, pending
   );
endinterface
`default_nettype wire

// File: rtl/pwm_compare_channel.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_compare_channel
//  Purpose  : One PWM output: compares the shared period count against the
//             channel threshold and registers the result.
//  Ports    : clock, reset_n        clock / async active-low reset
//             enable                1 = update q, 0 = hold q
//             count, period         shared counter and active period
//             threshold, mode       explicit duty and channel mode
//             q                     registered PWM output (lags count by 1)
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_compare_channel
   import pwm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  wire logic             clock,
   input  wire logic             reset_n,
   input  wire logic             enable,
   input  wire logic [WIDTH-1:0] count,
   input  wire logic [WIDTH-1:0] period,
   input  wire logic [WIDTH-1:0] threshold,
   input  wire logic             mode,
   output logic                  q
);

   logic [WIDTH-1:0] w_thr;

   assign w_thr = WIDTH'(threshold_sel(mode, wide_t'(threshold), wide_t'(period)));

   // Since count never exceeds period-1, a threshold >= period keeps q high
   // and a zero threshold keeps it low without extra logic.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q <= 1'b0;
      end else if (period == '0) begin
         q <= 1'b0;
      end else if (enable) begin
         q <= (count < w_thr);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pwm_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_clock_divider
//  Purpose  : Clock divider / multi-channel PWM generator. A shared
//             free-running period counter feeds CHANNELS comparators. New
//             period/duty/mode values are held in a shadow set and applied
//             only at a period wrap (or immediately when not counting).
//  Ports    : clock    system clock, rising edge
//             reset_n  asynchronous active-low reset
//             bus      pwm_clock_divider_if.slave
//                      (enable, load, period_in, duty_in, mode_in,
//                       q, tick, pending)
//  Params   : WIDTH    counter/period/duty width (<= pwm_pkg::MAX_WIDTH)
//             CHANNELS number of PWM outputs (1..8)
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_clock_divider
   import pwm_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 2
) (
   input  wire logic         clock,
   input  wire logic         reset_n,
   pwm_clock_divider_if.slave bus
);

   logic [WIDTH-1:0]          r_count;
   logic [WIDTH-1:0]          r_act_period;
   logic [CHANNELS*WIDTH-1:0] r_act_duty;
   logic [CHANNELS-1:0]       r_act_mode;
   logic [WIDTH-1:0]          r_sh_period;
   logic [CHANNELS*WIDTH-1:0] r_sh_duty;
   logic [CHANNELS-1:0]       r_sh_mode;
   logic                      r_pending;
   logic                      r_tick;

   logic                      w_running;
   logic                      w_wrap;
   logic [CHANNELS-1:0]       w_q;

   assign w_running = bus.enable && (r_act_period != '0);
   assign w_wrap    = w_running && (r_count == (r_act_period - WIDTH'(1)));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_count      <= '0;
         r_act_period <= '0;
         r_act_duty   <= '0;
         r_act_mode   <= {CHANNELS{MODE_HALF}};
         r_sh_period  <= '0;
         r_sh_duty    <= '0;
         r_sh_mode    <= {CHANNELS{MODE_HALF}};
         r_pending    <= 1'b0;
         r_tick       <= 1'b0;
      end else begin
         // Paused or halted cycles can never wrap, so tick drops to 0 there.
         r_tick <= w_wrap;

         if (w_running) begin
            if (w_wrap) begin
               r_count <= '0;
               if (bus.load) begin
                  // Load coinciding with the wrap bypasses the shadow.
                  r_act_period <= bus.period_in;
                  r_act_duty   <= bus.duty_in;
                  r_act_mode   <= bus.mode_in;
                  r_sh_period  <= bus.period_in;
                  r_sh_duty    <= bus.duty_in;
                  r_sh_mode    <= bus.mode_in;
                  r_pending    <= 1'b0;
               end else if (r_pending) begin
                  r_act_period <= r_sh_period;
                  r_act_duty   <= r_sh_duty;
                  r_act_mode   <= r_sh_mode;
                  r_pending    <= 1'b0;
               end
            end else begin
               r_count <= r_count + WIDTH'(1);
               if (bus.load) begin
                  r_sh_period <= bus.period_in;
                  r_sh_duty   <= bus.duty_in;
                  r_sh_mode   <= bus.mode_in;
                  r_pending   <= 1'b1;
               end
            end
         end else begin
            // Not counting: no wrap will come, so a captured shadow is applied
            // on the following cycle and the counter restarts from zero.
            if (bus.load) begin
               r_sh_period <= bus.period_in;
               r_sh_duty   <= bus.duty_in;
               r_sh_mode   <= bus.mode_in;
               r_pending   <= 1'b1;
            end else if (r_pending) begin
               r_act_period <= r_sh_period;
               r_act_duty   <= r_sh_duty;
               r_act_mode   <= r_sh_mode;
               r_pending    <= 1'b0;
               r_count      <= '0;
            end else if (r_act_period == '0) begin
               r_count <= '0;
            end
         end
      end
   end

   generate
      for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
         pwm_compare_channel #(
            .WIDTH (WIDTH)
         ) u_channel (
            .clock     (clock),
            .reset_n   (reset_n),
            .enable    (bus.enable),
            .count     (r_count),
            .period    (r_act_period),
            .threshold (r_act_duty[i*WIDTH +: WIDTH]),
            .mode      (r_act_mode[i]),
            .q         (w_q[i])
         );
      end
   endgenerate

   assign bus.q       = w_q;
   assign bus.tick    = r_tick;
   assign bus.pending = r_pending;

endmodule
`default_nettype wire
